// File: rtl/qbus_arbiter.sv
// Q-bus mastership controller: arbitrates between the CPU and one DMA master,
// runs the DMR/DMGO/SACK handshake and flags bus cycles that never see RPLY.
module qbus_arbiter #(
  parameter int unsigned TIMEOUT       = 63,
  parameter int unsigned GRANT_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       cpu_req,
  input  logic       cpu_sync,
  input  logic       dma_sync,
  input  logic       rply,
  input  logic       dmr,
  input  logic       sack,
  output logic       dmgo,
  output logic       cpu_hold,
  output logic       owner,
  output logic       berr,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CPU   = 2'd1,
    S_GRANT = 2'd2,
    S_DMA   = 2'd3
  } state_t;

  localparam logic [7:0] BUS_LIMIT   = 8'(TIMEOUT);
  localparam logic [7:0] GRANT_LIMIT = 8'(GRANT_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       fired_q, fired_d;
  logic       berr_q, berr_d;
  logic       cpu_turn_q, cpu_turn_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] c, input logic [7:0] lim);
    return (c >= lim) ? lim : c + 8'd1;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    fired_d    = fired_q;
    berr_d     = 1'b0;
    cpu_turn_d = cpu_turn_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d   = 8'd0;
        fired_d = 1'b0;
        if (!cpu_req) cpu_turn_d = 1'b0;
        if (cpu_sync) begin
          state_d    = S_CPU;
          cpu_turn_d = 1'b0;
        end else if (dmr && !cpu_turn_q) begin
          state_d = S_GRANT;
        end
      end

      S_CPU: begin
        if (rply) begin
          cnt_d = 8'd0;
        end else begin
          cnt_d = sat_inc(cnt_q, BUS_LIMIT);
          if (cnt_d == BUS_LIMIT && !fired_q) begin
            berr_d  = 1'b1;
            fired_d = 1'b1;
          end
        end
        if (!cpu_sync) state_d = S_IDLE;
      end

      S_GRANT: begin
        cnt_d = sat_inc(cnt_q, GRANT_LIMIT);
        if (sack)                              state_d = S_DMA;
        else if (!dmr || cnt_d == GRANT_LIMIT) state_d = S_IDLE;
      end

      S_DMA: begin
        // A dropped dma_sync closes the DMA cycle, re-arming the error pulse.
        if (!dma_sync) begin
          cnt_d   = 8'd0;
          fired_d = 1'b0;
        end else if (rply) begin
          cnt_d = 8'd0;
        end else begin
          cnt_d = sat_inc(cnt_q, BUS_LIMIT);
          if (cnt_d == BUS_LIMIT && !fired_q) begin
            berr_d  = 1'b1;
            fired_d = 1'b1;
          end
        end
        if (!sack) begin
          state_d    = S_IDLE;
          cpu_turn_d = cpu_req;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d   = 8'd0;
      fired_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      fired_q    <= 1'b0;
      berr_q     <= 1'b0;
      cpu_turn_q <= 1'b0;
    end else if (ce) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fired_q    <= fired_d;
      berr_q     <= berr_d;
      cpu_turn_q <= cpu_turn_d;
    end
  end

  // Decoded straight from the state flops: no input reaches an output combinationally.
  assign dmgo     = (state_q == S_GRANT);
  assign owner    = (state_q == S_DMA);
  assign cpu_hold = (state_q == S_GRANT) || (state_q == S_DMA);
  assign berr     = berr_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_qbus_arbiter.sv
// Directed bench for qbus_arbiter (TIMEOUT=4, GRANT_TIMEOUT=3); expected outputs hand-computed.
module tb_qbus_arbiter;

  logic       clk = 1'b0;
  logic       reset_n, ce, cpu_req, cpu_sync, dma_sync, rply, dmr, sack;
  logic       dmgo, cpu_hold, owner, berr;
  logic [1:0] state_o;

  int passed = 0;
  int total  = 0;

  qbus_arbiter #(.TIMEOUT(4), .GRANT_TIMEOUT(3)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .cpu_req(cpu_req), .cpu_sync(cpu_sync),
    .dma_sync(dma_sync), .rply(rply), .dmr(dmr), .sack(sack), .dmgo(dmgo),
    .cpu_hold(cpu_hold), .owner(owner), .berr(berr), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected vector is {state, owner, dmgo, cpu_hold, berr}.
  task automatic expect_outs(input string tag, input logic [1:0] st, input logic ow,
                             input logic dg, input logic ho, input logic be);
    logic [5:0] obs, exp;
    obs = {state_o, owner, dmgo, cpu_hold, berr};
    exp = {st, ow, dg, ho, be};
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed st/own/dmgo/hold/berr=%b required %b", tag, obs, exp);
  endtask

  initial begin
    reset_n = 1'b0; ce = 1'b1; cpu_req = 1'b0; cpu_sync = 1'b0; dma_sync = 1'b0;
    rply = 1'b0; dmr = 1'b0; sack = 1'b0;
    #1;
    expect_outs("reset", 2'd0, 0, 0, 0, 0);
    tick(); tick();
    reset_n = 1'b1;

    // CPU read, RPLY on the third tick
    cpu_req = 1; cpu_sync = 1;
    tick(); expect_outs("cpu_enter", 2'd1, 0, 0, 0, 0);
    tick(); tick(); expect_outs("cpu_wait", 2'd1, 0, 0, 0, 0);
    rply = 1;
    tick(); expect_outs("cpu_rply", 2'd1, 0, 0, 0, 0);
    cpu_sync = 0; rply = 0; cpu_req = 0;
    tick(); expect_outs("cpu_done", 2'd0, 0, 0, 0, 0);

    // DMA grant, sack two ticks after dmgo, held five ticks
    dmr = 1;
    tick(); expect_outs("grant_1", 2'd2, 0, 1, 1, 0);
    tick(); expect_outs("grant_2", 2'd2, 0, 1, 1, 0);
    sack = 1; dmr = 0;
    tick(); expect_outs("dma_enter", 2'd3, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      tick(); expect_outs("dma_hold", 2'd3, 1, 0, 1, 0);
    end
    sack = 0;
    tick(); expect_outs("dma_release", 2'd0, 0, 0, 0, 0);

    // Simultaneous cpu_sync and dmr: CPU first, grant the tick after SYNC drops
    cpu_req = 1; cpu_sync = 1; dmr = 1;
    tick(); expect_outs("race_cpu", 2'd1, 0, 0, 0, 0);
    tick(); expect_outs("race_cpu_hold", 2'd1, 0, 0, 0, 0);
    cpu_sync = 0; cpu_req = 0;
    tick(); expect_outs("race_idle", 2'd0, 0, 0, 0, 0);
    tick(); expect_outs("race_grant", 2'd2, 0, 1, 1, 0);
    dmr = 0;
    tick(); expect_outs("grant_withdrawn", 2'd0, 0, 0, 0, 0);

    // CPU bus timeout: berr on the 4th tick, once; ce=0 freezes the pulse
    cpu_req = 1; cpu_sync = 1;
    tick(); expect_outs("to_enter", 2'd1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); expect_outs("to_pre", 2'd1, 0, 0, 0, 0);
    end
    tick(); expect_outs("to_berr", 2'd1, 0, 0, 0, 1);
    ce = 0;
    tick(); tick(); expect_outs("ce_freeze", 2'd1, 0, 0, 0, 1);
    ce = 1;
    tick(); expect_outs("to_berr_end", 2'd1, 0, 0, 0, 0);
    rply = 1;
    tick(); rply = 0;
    for (int i = 0; i < 5; i++) begin
      tick(); expect_outs("to_once", 2'd1, 0, 0, 0, 0);
    end
    cpu_sync = 0; cpu_req = 0;
    tick(); expect_outs("to_idle", 2'd0, 0, 0, 0, 0);

    // Grant timeout, then re-offer while dmr stays high
    dmr = 1;
    tick(); expect_outs("gto_1", 2'd2, 0, 1, 1, 0);
    tick(); tick(); expect_outs("gto_3", 2'd2, 0, 1, 1, 0);
    tick(); expect_outs("gto_drop", 2'd0, 0, 0, 0, 0);
    tick(); expect_outs("gto_reoffer", 2'd2, 0, 1, 1, 0);

    // DMA bus timeout
    sack = 1; dmr = 0; dma_sync = 1;
    tick(); expect_outs("dto_enter", 2'd3, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); expect_outs("dto_pre", 2'd3, 1, 0, 1, 0);
    end
    tick(); expect_outs("dto_berr", 2'd3, 1, 0, 1, 1);
    tick(); expect_outs("dto_once", 2'd3, 1, 0, 1, 0);
    dma_sync = 0;
    tick();

    // Fairness: tenure ends with cpu_req and dmr high, grant waits for one CPU cycle
    cpu_req = 1; dmr = 1; sack = 0;
    tick(); expect_outs("fair_release", 2'd0, 0, 0, 0, 0);
    tick(); tick(); expect_outs("fair_blocked", 2'd0, 0, 0, 0, 0);
    cpu_sync = 1;
    tick(); expect_outs("fair_cpu", 2'd1, 0, 0, 0, 0);
    cpu_sync = 0;
    tick(); expect_outs("fair_cpu_done", 2'd0, 0, 0, 0, 0);
    tick(); expect_outs("fair_grant", 2'd2, 0, 1, 1, 0);
    sack = 1; dmr = 0; cpu_req = 0;
    tick(); expect_outs("rst_dma", 2'd3, 1, 0, 1, 0);

    // Asynchronous reset mid-tenure
    reset_n = 0;
    #1;
    expect_outs("rst_async", 2'd0, 0, 0, 0, 0);
    sack = 0;
    #2;
    reset_n = 1;
    tick(); expect_outs("rst_after", 2'd0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
